// File: rtl/data_mem_resp_pkg.sv
// Shared encodings for the data-memory responder:
// access size codes and responder FSM states.
package data_mem_resp_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Replicate the low-aligned store data across every lane it may land in.
    function automatic logic [31:0] store_lanes(
        input logic [1:0]  size,
        input logic [31:0] wdata
    );
        logic [31:0] lanes;
        lanes = wdata;
        if (size == SIZE_HALF) lanes = {2{wdata[15:0]}};
        if (size == SIZE_BYTE) lanes = {4{wdata[7:0]}};
        return lanes;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering for byte/halfword/word accesses:
// store merge, byte enables, zero-extended load data, misalignment.
module mem_lane_align
    import data_mem_resp_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_old,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_wword,
    output logic [3:0]  o_be,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [31:0] w_lanes;

    // Decode lanes from size and low address bits, then merge into the old word.
    always_comb begin
        w_lanes    = store_lanes(i_size, i_wdata);
        o_be       = 4'b0000;
        o_rdata    = 32'h0;
        o_misalign = 1'b0;
        case (i_size)
            SIZE_WORD: begin
                o_be       = 4'b1111;
                o_rdata    = i_old;
                o_misalign = (i_addr != 2'b00);
            end
            SIZE_HALF: begin
                o_be       = i_addr[1] ? 4'b1100 : 4'b0011;
                o_rdata    = {16'h0, i_addr[1] ? i_old[31:16] : i_old[15:0]};
                o_misalign = i_addr[0];
            end
            SIZE_BYTE: begin
                o_be    = 4'b0001 << i_addr;
                o_rdata = {24'h0, i_old[{i_addr, 3'b000} +: 8]};
            end
            default: begin
                o_be = 4'b0000;
            end
        endcase
        o_wword = i_old;
        for (int i = 0; i < 4; i++) begin
            if (o_be[i]) o_wword[8*i +: 8] = w_lanes[8*i +: 8];
        end
    end

endmodule

// File: rtl/data_mem_resp.sv
// Data-bus slave: captures one access, counts wait states, commits
// the store or returns load data with a one-cycle active-low ack.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MREQ,
    input  logic        WRITE,
    input  logic [1:0]  SIZE,
    input  logic [31:0] DAD,
    inout  wire  [31:0] DDT,
    output logic        ACKD_n,
    output logic        ERR
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LP_SPAN = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  LP_WAIT = 4'(WAIT_CYCLES);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [1:0]  r_size;
    logic [31:0] r_dad;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_oe;
    logic        r_ackd_n;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic          w_oor;
    logic [31:0]   w_old;
    logic [31:0]   w_wword;
    logic [3:0]    w_be;
    logic [31:0]   w_ldata;
    logic          w_mis;
    logic          w_fault;
    logic          w_req_new;
    logic          w_take;
    logic          w_fire;

    // Offsets below the base wrap to large values and fault as out of range.
    assign w_off   = r_dad - BASE_ADDR;
    assign w_oor   = {1'b0, w_off} >= LP_SPAN;
    assign w_idx   = w_off[AW+1:2];
    assign w_old   = r_mem[w_idx];
    assign w_fault = (r_size == SIZE_ILL) | w_mis | w_oor;

    assign w_req_new = MREQ & ((WRITE != r_write) |
                               (SIZE != r_size) |
                               (DAD != r_dad));
    assign w_take = ((r_state == ST_IDLE) & MREQ) |
                    ((r_state == ST_HOLD) & w_req_new);
    assign w_fire = (r_state == ST_WAIT) & (r_cnt == 4'd0);

    mem_lane_align u_align (
        .i_size     (r_size),
        .i_addr     (w_off[1:0]),
        .i_old      (w_old),
        .i_wdata    (r_wdata),
        .o_wword    (w_wword),
        .o_be       (w_be),
        .o_rdata    (w_ldata),
        .o_misalign (w_mis)
    );

    // Capture the request so bus changes during the wait are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write <= 1'b0;
            r_size  <= SIZE_WORD;
            r_dad   <= 32'h0;
            r_wdata <= 32'h0;
        end else if (w_take) begin
            r_write <= WRITE;
            r_size  <= SIZE;
            r_dad   <= DAD;
            r_wdata <= DDT;
        end
    end

    // Handshake FSM with wait counter and registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_ackd_n <= 1'b1;
            r_err    <= 1'b0;
            r_oe     <= 1'b0;
            r_rdata  <= 32'h0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (MREQ) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= LP_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= ST_ACK;
                        r_ackd_n <= 1'b0;
                        r_err    <= w_fault;
                        r_oe     <= ~r_write;
                        r_rdata  <= (r_write | w_fault) ? 32'h0 : w_ldata;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    r_state  <= ST_HOLD;
                    r_ackd_n <= 1'b1;
                    r_err    <= 1'b0;
                    r_oe     <= 1'b0;
                end
                ST_HOLD: begin
                    if (!MREQ) begin
                        r_state <= ST_IDLE;
                    end else if (w_req_new) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= LP_WAIT;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Commit a legal store on the edge that enters the ack cycle.
    always_ff @(posedge clk) begin
        if (!rst && w_fire && r_write && !w_fault && (|w_be)) begin
            r_mem[w_idx] <= w_wword;
        end
    end

    assign DDT    = r_oe ? r_rdata : 32'bz;
    assign ACKD_n = r_ackd_n;
    assign ERR    = r_err;

endmodule
